// File: rtl/ip_stride_conf_pf_pkg.sv
// Shared address geometry, payload types and helpers for the IP-indexed stride prefetcher.
package ip_stride_pkg;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LOG2_BLOCK = 6;
  localparam int unsigned LOG2_PAGE  = 12;
  localparam int unsigned CLA_W      = ADDR_W - LOG2_BLOCK;
  localparam int unsigned PAGE_SH    = LOG2_PAGE - LOG2_BLOCK;
  localparam int unsigned PAGE_W     = ADDR_W - LOG2_PAGE;
  localparam int unsigned DROP_W     = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CLA_W-1:0]  cla_t;
  typedef logic [CLA_W-1:0]  stride_t;
  typedef logic [PAGE_W-1:0] page_t;

  typedef struct packed {
    logic    valid;
    addr_t   ip;
    cla_t    last_cla;
    stride_t last_stride;
  } tracker_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } iss_state_e;

  function automatic cla_t cla_of(input addr_t addr);
    return addr[ADDR_W-1:LOG2_BLOCK];
  endfunction

  function automatic page_t page_of(input cla_t cla);
    return cla[CLA_W-1:PAGE_SH];
  endfunction

  function automatic addr_t line_addr(input cla_t cla);
    return {cla, {LOG2_BLOCK{1'b0}}};
  endfunction

endpackage

// File: rtl/ip_stride_conf_pf_if.sv
// Demand-training and prefetch-issue signals of the stride prefetcher, named from the prefetcher's side.
interface ip_stride_conf_pf_if;
  import ip_stride_pkg::*;

  logic              acc_valid_i;
  addr_t             acc_addr_i;
  addr_t             acc_ip_i;
  logic              pf_valid_o;
  addr_t             pf_addr_o;
  logic              pf_ready_i;
  logic              busy_o;
  logic [DROP_W-1:0] drop_count_o;

  modport slave (
    input  acc_valid_i, acc_addr_i, acc_ip_i, pf_ready_i,
    output pf_valid_o, pf_addr_o, busy_o, drop_count_o
  );

  modport master (
    output acc_valid_i, acc_addr_i, acc_ip_i, pf_ready_i,
    input  pf_valid_o, pf_addr_o, busy_o, drop_count_o
  );

endinterface

// File: rtl/ip_stride_conf_pf_issuer.sv
// Issues one in-page prefetch line per handshake for each accepted trigger; counts triggers lost to a busy burst.
module ip_stride_pf_issuer
  import ip_stride_pkg::*;
#(
  parameter int unsigned DEGREE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_i,
  input  cla_t              base_i,
  input  stride_t           stride_i,
  input  logic              pf_ready_i,
  output logic              pf_valid_o,
  output addr_t             pf_addr_o,
  output logic              busy_o,
  output logic [DROP_W-1:0] drop_count_o
);

  localparam int unsigned K_W = $clog2(DEGREE + 1);

  iss_state_e        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  cla_t              cur_q, cur_d;
  stride_t           stride_q, stride_d;
  page_t             page_q, page_d;
  logic              pf_valid_q, pf_valid_d;
  addr_t             pf_addr_q, pf_addr_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  cla_t first_c;
  cla_t next_c;
  logic first_ok_c;
  logic hs_c;
  logic last_c;
  logic start_c;
  logic drop_c;

  // A burst ends on its DEGREE-th handshake or when the following line would leave the page.
  assign first_c    = base_i + stride_i;
  assign next_c     = cur_q + stride_q;
  assign first_ok_c = (page_of(first_c) == page_of(base_i));
  assign hs_c       = pf_valid_q && pf_ready_i;
  assign last_c     = hs_c && ((k_q == K_W'(DEGREE)) || (page_of(next_c) != page_q));
  assign start_c    = trig_i && first_ok_c && ((state_q == ST_IDLE) || last_c);
  assign drop_c     = trig_i && (state_q == ST_ISSUE) && !last_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      cur_q      <= '0;
      stride_q   <= '0;
      page_q     <= '0;
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cur_q      <= cur_d;
      stride_q   <= stride_d;
      page_q     <= page_d;
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cur_d      = cur_q;
    stride_d   = stride_q;
    page_d     = page_q;
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    busy_d     = busy_q;
    drop_d     = drop_q;

    case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_ISSUE;
      ST_ISSUE: if (last_c && !start_c) state_d = ST_IDLE;
    endcase

    if (start_c) begin
      k_d        = K_W'(1);
      cur_d      = first_c;
      stride_d   = stride_i;
      page_d     = page_of(base_i);
      pf_valid_d = 1'b1;
      pf_addr_d  = line_addr(first_c);
    end else if (last_c) begin
      pf_valid_d = 1'b0;
    end else if (hs_c) begin
      k_d       = k_q + K_W'(1);
      cur_d     = next_c;
      pf_addr_d = line_addr(next_c);
    end

    busy_d = (state_d == ST_ISSUE);

    if (drop_c && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  assign pf_valid_o   = pf_valid_q;
  assign pf_addr_o    = pf_addr_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/ip_stride_conf_pf.sv
// IP-indexed stride prefetcher: fully associative tracker table with LRU replacement and
// saturating per-IP confidence; qualified triggers feed the burst issuer.
module ip_stride_conf_pf
  import ip_stride_pkg::*;
#(
  parameter int unsigned NUM_TRACKERS = 64,
  parameter int unsigned DEGREE       = 4,
  parameter int unsigned CONF_BITS    = 2,
  parameter int unsigned CONF_THRESH  = 2
) (
  input logic                clk,
  input logic                rst,
  ip_stride_conf_pf_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_TRACKERS);

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [CONF_BITS-1:0] conf_t;

  localparam conf_t CONF_MAX = {CONF_BITS{1'b1}};

  tracker_t trk_q  [NUM_TRACKERS];
  tracker_t trk_d  [NUM_TRACKERS];
  conf_t    conf_q [NUM_TRACKERS];
  conf_t    conf_d [NUM_TRACKERS];
  idx_t     age_q  [NUM_TRACKERS];
  idx_t     age_d  [NUM_TRACKERS];

  cla_t    acc_cla_c;
  logic    hit_c;
  logic    inv_found_c;
  idx_t    hit_idx_c;
  idx_t    inv_idx_c;
  idx_t    lru_idx_c;
  idx_t    sel_idx_c;
  stride_t stride_c;
  logic    same_c;
  conf_t   conf_inc_c;
  logic    trig_c;

  assign acc_cla_c = cla_of(bus.acc_addr_i);

  // CAM match plus victim candidates; descending scan leaves the lowest matching index.
  always_comb begin
    hit_c       = 1'b0;
    hit_idx_c   = '0;
    inv_found_c = 1'b0;
    inv_idx_c   = '0;
    lru_idx_c   = '0;
    for (int i = NUM_TRACKERS - 1; i >= 0; i--) begin
      if (trk_q[i].valid && (trk_q[i].ip == bus.acc_ip_i)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!trk_q[i].valid) begin
        inv_found_c = 1'b1;
        inv_idx_c   = IDX_W'(i);
      end
      if (age_q[i] == IDX_W'(NUM_TRACKERS - 1)) lru_idx_c = IDX_W'(i);
    end
  end

  assign sel_idx_c  = hit_c ? hit_idx_c : (inv_found_c ? inv_idx_c : lru_idx_c);
  assign stride_c   = acc_cla_c - trk_q[hit_idx_c].last_cla;
  assign same_c     = (stride_c == trk_q[hit_idx_c].last_stride);
  assign conf_inc_c = (conf_q[hit_idx_c] == CONF_MAX) ? CONF_MAX
                                                      : conf_q[hit_idx_c] + conf_t'(1);
  assign trig_c     = bus.acc_valid_i && hit_c && (stride_c != '0) && same_c &&
                      (conf_inc_c >= conf_t'(CONF_THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRACKERS; i++) begin
        trk_q[i]  <= '0;
        conf_q[i] <= '0;
        age_q[i]  <= IDX_W'(i);
      end
    end else begin
      trk_q  <= trk_d;
      conf_q <= conf_d;
      age_q  <= age_d;
    end
  end

  // Training: a zero stride only refreshes recency; a repeated stride builds confidence.
  always_comb begin
    trk_d  = trk_q;
    conf_d = conf_q;
    age_d  = age_q;
    if (bus.acc_valid_i) begin
      for (int i = 0; i < NUM_TRACKERS; i++) begin
        if (IDX_W'(i) == sel_idx_c) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[sel_idx_c]) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
      if (hit_c) begin
        if (stride_c != '0) begin
          trk_d[hit_idx_c].last_cla = acc_cla_c;
          if (same_c) begin
            conf_d[hit_idx_c] = conf_inc_c;
          end else begin
            conf_d[hit_idx_c]            = '0;
            trk_d[hit_idx_c].last_stride = stride_c;
          end
        end
      end else begin
        trk_d[sel_idx_c].valid       = 1'b1;
        trk_d[sel_idx_c].ip          = bus.acc_ip_i;
        trk_d[sel_idx_c].last_cla    = acc_cla_c;
        trk_d[sel_idx_c].last_stride = '0;
        conf_d[sel_idx_c]            = '0;
      end
    end
  end

  ip_stride_pf_issuer #(
    .DEGREE (DEGREE)
  ) u_issuer (
    .clk          (clk),
    .rst          (rst),
    .trig_i       (trig_c),
    .base_i       (acc_cla_c),
    .stride_i     (stride_c),
    .pf_ready_i   (bus.pf_ready_i),
    .pf_valid_o   (bus.pf_valid_o),
    .pf_addr_o    (bus.pf_addr_o),
    .busy_o       (bus.busy_o),
    .drop_count_o (bus.drop_count_o)
  );

endmodule

// File: tb/tb_ip_stride_conf_pf.sv
// Directed bench for ip_stride_conf_pf: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ip_stride_conf_pf;
  import ip_stride_pkg::*;

  localparam int NT   = 4;
  localparam int DEG  = 4;
  localparam int CMAX = 3;
  localparam int THR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ip_stride_conf_pf_if bus ();

  ip_stride_conf_pf #(
    .NUM_TRACKERS (NT),
    .DEGREE       (DEG),
    .CONF_BITS    (2),
    .CONF_THRESH  (THR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    bit          valid;
    logic [63:0] ip;
    logic [57:0] last_cla;
    logic [57:0] last_stride;
    int          conf;
  } mtrk_t;

  mtrk_t       mt [NT];
  int          lru [$];      // most recently used first
  logic [63:0] exp_q [$];    // addresses still to be handed over, head is presented
  int          m_drop;
  logic [63:0] hs_log [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      mt[i].valid       = 1'b0;
      mt[i].ip          = '0;
      mt[i].last_cla    = '0;
      mt[i].last_stride = '0;
      mt[i].conf        = 0;
    end
    lru.delete();
    for (int i = 0; i < NT; i++) lru.push_back(i);
    exp_q.delete();
    m_drop = 0;
  endtask

  task automatic model_step();
    bit          trig;
    bit          hs;
    int          idx;
    logic [57:0] cla;
    logic [57:0] s;
    logic [57:0] base;
    logic [57:0] st;
    logic [57:0] c;
    trig = 1'b0;
    base = '0;
    st   = '0;
    hs   = (exp_q.size() != 0) && bus.pf_ready_i;
    if (bus.acc_valid_i) begin
      cla = bus.acc_addr_i[63:6];
      idx = -1;
      for (int i = 0; i < NT; i++)
        if (mt[i].valid && mt[i].ip == bus.acc_ip_i) idx = i;
      if (idx >= 0) begin
        s = cla - mt[idx].last_cla;
        if (s != '0) begin
          if (s == mt[idx].last_stride) begin
            mt[idx].conf     = (mt[idx].conf < CMAX) ? mt[idx].conf + 1 : CMAX;
            mt[idx].last_cla = cla;
            if (mt[idx].conf >= THR) begin
              trig = 1'b1;
              base = cla;
              st   = s;
            end
          end else begin
            mt[idx].conf        = 0;
            mt[idx].last_stride = s;
            mt[idx].last_cla    = cla;
          end
        end
      end else begin
        for (int i = NT - 1; i >= 0; i--) if (!mt[i].valid) idx = i;
        if (idx < 0) idx = lru[$];
        mt[idx].valid       = 1'b1;
        mt[idx].ip          = bus.acc_ip_i;
        mt[idx].last_cla    = cla;
        mt[idx].last_stride = '0;
        mt[idx].conf        = 0;
      end
      for (int p = 0; p < lru.size(); p++) begin
        if (lru[p] == idx) begin
          lru.delete(p);
          break;
        end
      end
      lru.push_front(idx);
    end
    if (hs) void'(exp_q.pop_front());
    if (trig) begin
      if (exp_q.size() == 0) begin
        for (int k = 1; k <= DEG; k++) begin
          c = base + 58'(k) * st;
          if (c[57:6] != base[57:6]) break;
          exp_q.push_back({c, 6'b0});
        end
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("pf_valid", 64'(bus.pf_valid_o), 64'(exp_q.size() != 0));
      check("busy", 64'(bus.busy_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("pf_addr", bus.pf_addr_o, exp_q[0]);
      check("drop_count", 64'(bus.drop_count_o), 64'(m_drop));
      if (bus.pf_valid_o && bus.pf_ready_i) hs_log.push_back(bus.pf_addr_o);
    end
  end

  task automatic cyc(input bit v, input logic [63:0] a, input logic [63:0] ip, input bit rdy);
    @(posedge clk);
    #1;
    bus.acc_valid_i = v;
    bus.acc_addr_i  = a;
    bus.acc_ip_i    = ip;
    bus.pf_ready_i  = rdy;
  endtask

  task automatic acc(input logic [63:0] a, input logic [63:0] ip, input bit rdy = 1'b1);
    cyc(1'b1, a, ip, rdy);
  endtask

  task automatic idle(input int n, input bit rdy = 1'b1);
    repeat (n) cyc(1'b0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.acc_valid_i = 1'b0;
    bus.pf_ready_i  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs_log.delete();
  endtask

  task automatic check_log(input string name, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, "_count"}, 64'(hs_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check(name, (i < hs_log.size()) ? hs_log[i] : 64'hDEAD, e[i]);
  endtask

  initial begin
    bus.acc_valid_i = 1'b0;
    bus.acc_addr_i  = '0;
    bus.acc_ip_i    = '0;
    bus.pf_ready_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pf_valid", 64'(bus.pf_valid_o), 64'd0);
    check("reset_pf_addr", bus.pf_addr_o, 64'd0);
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    check("reset_drop", 64'(bus.drop_count_o), 64'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    hs_log.delete();

    // Ascending stride, full burst of four
    do_reset();
    acc(64'h1000, 64'h400); acc(64'h1040, 64'h400); acc(64'h1080, 64'h400); acc(64'h10C0, 64'h400);
    check("t1_no_pf_after_3", 64'(bus.pf_valid_o), 64'd0);
    idle(1);
    check("t1_first_valid", 64'(bus.pf_valid_o), 64'd1);
    check("t1_first_addr", bus.pf_addr_o, 64'h1100);
    idle(4);
    check("t1_busy_done", 64'(bus.busy_o), 64'd0);
    check_log("t1_hs", 64'h1100, 64'h1140, 64'h1180, 64'h11C0);

    // Burst clipped at the page end, and a trigger whose first line is already out of page
    do_reset();
    acc(64'h1EC0, 64'h400); acc(64'h1F00, 64'h400); acc(64'h1F40, 64'h400); acc(64'h1F80, 64'h400);
    idle(1);
    check("t2_addr", bus.pf_addr_o, 64'h1FC0);
    idle(1);
    check("t2_busy_done", 64'(bus.busy_o), 64'd0);
    check("t2_drop", 64'(bus.drop_count_o), 64'd0);
    check("t2_hs_count", 64'(hs_log.size()), 64'd1);
    acc(64'h2F00, 64'h410); acc(64'h2F40, 64'h410); acc(64'h2F80, 64'h410); acc(64'h2FC0, 64'h410);
    idle(1);
    check("t2b_ignored", 64'(bus.pf_valid_o), 64'd0);
    check("t2b_drop", 64'(bus.drop_count_o), 64'd0);

    // Negative stride
    do_reset();
    acc(64'h2300, 64'h500); acc(64'h22C0, 64'h500); acc(64'h2280, 64'h500); acc(64'h2240, 64'h500);
    idle(6);
    check_log("t3_hs", 64'h2200, 64'h21C0, 64'h2180, 64'h2140);

    // Backpressure for five cycles after the first handshake
    do_reset();
    acc(64'h4000, 64'h600); acc(64'h4040, 64'h600); acc(64'h4080, 64'h600); acc(64'h40C0, 64'h600);
    idle(1, 1'b1);
    idle(5, 1'b0);
    check("t4_stall_valid", 64'(bus.pf_valid_o), 64'd1);
    check("t4_stall_addr", bus.pf_addr_o, 64'h4140);
    idle(6, 1'b1);
    check_log("t4_hs", 64'h4100, 64'h4140, 64'h4180, 64'h41C0);

    // Trigger on the final handshake, a dropped trigger while stalled, then reset mid-burst
    do_reset();
    acc(64'h5000, 64'h700); acc(64'h5040, 64'h700); acc(64'h5080, 64'h700); acc(64'h50C0, 64'h700);
    idle(3);
    acc(64'h5100, 64'h700);
    idle(1);
    check("t5_no_bubble_valid", 64'(bus.pf_valid_o), 64'd1);
    check("t5_no_bubble_addr", bus.pf_addr_o, 64'h5140);
    acc(64'h5140, 64'h700, 1'b0);
    idle(1, 1'b0);
    check("t5_drop", 64'(bus.drop_count_o), 64'd1);
    check("t5_stall_addr", bus.pf_addr_o, 64'h5180);
    do_reset();
    check("t5_rst_valid", 64'(bus.pf_valid_o), 64'd0);
    check("t5_rst_busy", 64'(bus.busy_o), 64'd0);
    check("t5_rst_drop", 64'(bus.drop_count_o), 64'd0);
    idle(3);
    check("t5_drop_after", 64'(bus.drop_count_o), 64'd0);

    // LRU replacement: E evicts B, so B retrains from zero confidence
    do_reset();
    acc(64'h10000, 64'hA00); acc(64'h20000, 64'hB00); acc(64'h30000, 64'hC00);
    acc(64'h40000, 64'hD00); acc(64'h10040, 64'hA00); acc(64'h50000, 64'hE00);
    acc(64'h20040, 64'hB00); acc(64'h20080, 64'hB00); acc(64'h200C0, 64'hB00); acc(64'h20100, 64'hB00);
    check("t6_no_pf_after_3", 64'(bus.pf_valid_o), 64'd0);
    idle(1);
    check("t6_valid", 64'(bus.pf_valid_o), 64'd1);
    check("t6_addr", bus.pf_addr_o, 64'h20140);
    idle(5);
    check_log("t6_hs", 64'h20140, 64'h20180, 64'h201C0, 64'h20200);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_stride_conf_pf.md
Name: ip_stride_conf_pf

Overview:
Next-generation IP-indexed stride prefetcher with parametrised tracker count, prefetch degree, page size and confidence threshold. It trains on demand accesses (valid-qualified) and keeps per-IP saturating confidence. Qualified triggers are issued one prefetch line per cycle through a valid/ready port toward the prefetch queue. It sits beside the L1D/L2 request path.

Parameters:
ADDR_W, 64, address/IP width
LOG2_BLOCK, 6, log2 cache-line bytes
LOG2_PAGE, 12, log2 page bytes; prefetches never cross the trigger's page
NUM_TRACKERS, 64, tracker entries, fully associative (power of 2, >=2)
DEGREE, 4, max prefetches per trigger (1..8)
CONF_BITS, 2, confidence counter width
CONF_THRESH, 2, min confidence (post-update) to trigger (1..2^CONF_BITS-1)

Ports:
clk  in  1  clock
rst  in  1  reset
acc_valid_i  in  1  demand access valid; always accepted
acc_addr_i  in  ADDR_W  demand byte address
acc_ip_i  in  ADDR_W  instruction pointer of access
pf_valid_o  out  1  prefetch address valid
pf_addr_o  out  ADDR_W  line-aligned prefetch byte address
pf_ready_i  in  1  downstream accepts prefetch
busy_o  out  1  issuer in ISSUE state
drop_count_o  out  16  saturating count of discarded triggers

Behaviour:
- Reset: the clock is clk; reset is rst, synchronous and active-high. On reset: all trackers invalid, LRU ages = index, pf_valid_o=0, pf_addr_o=0, busy_o=0, drop_count_o=0, FSM=IDLE. Reset mid-burst aborts it; nothing is counted.
- Widths: cla = addr>>LOG2_BLOCK (CLA_W=ADDR_W-LOG2_BLOCK). stride = cla - last_cla, signed two's complement, CLA_W bits, wrap-around arithmetic.
- Tracker fields: valid, ip, last_cla, last_stride, conf[CONF_BITS], age.
- Training (acc_valid_i=1; all state updated at the next edge):
  - Hit, stride==0: only the LRU ages update.
  - Hit, stride==last_stride: conf++ (saturating); last_cla<=cla.
  - Hit, stride!=last_stride: conf<=0; last_stride<=stride; last_cla<=cla.
  - Miss: allocate the lowest-index invalid entry, else the entry with age==NUM_TRACKERS-1. New entry: ip, last_cla=cla, last_stride=0, conf=0.
  - LRU: the touched entry's age<=0. Entries with age below its old age increment. Ages always form a permutation.
- Trigger: hit && stride!=0 && stride==last_stride && updated conf>=CONF_THRESH. Latches base cla, stride and trigger page.
- Issuer FSM:
  - IDLE: on a trigger, go to ISSUE with k=1. pf_valid_o=1 starting the cycle after the access edge (1-cycle latency).
  - ISSUE: pf_addr_o=(base+k*stride)<<LOG2_BLOCK. On a pf_valid_o&&pf_ready_i handshake, k++.
  - The burst ends after the k=DEGREE handshake, or when the next address leaves the trigger page. An out-of-page address is never presented. If k=1 is already out of page, the trigger is ignored with no drop.
  - pf_valid_o/pf_addr_o hold stable while pf_ready_i=0. Valid never deasserts without a handshake.
- Simultaneous events:
  - A trigger arriving in ISSUE is discarded and drop_count_o++ (saturates at 0xFFFF).
  - Exception: a trigger in the same cycle as the burst's final handshake is accepted; the new burst is presented next cycle with no bubble.
  - Training continues unaffected during ISSUE.
- busy_o = (state==ISSUE).

Decomposition:
- Package ip_stride_pkg: ADDR_W-derived addr_t, cla_t, stride_t typedefs; tracker_t struct; page_of() and line_addr() helper functions.
- Sub-module ip_stride_pf_issuer: IDLE/ISSUE FSM, k counter, page check, handshake, drop counter.
- Top module: tracker array, CAM match, LRU, confidence logic.

Test Plan (LOG2_BLOCK=6, LOG2_PAGE=12, DEGREE=4, CONF_THRESH=2, pf_ready_i=1 unless stated):
1. IP 0x400, addresses 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles -> no prefetch for the first three. After the fourth: 0x1100, 0x1140, 0x1180, 0x11C0 on 4 consecutive cycles, then busy_o=0.
2. Same training, continued to trigger at 0x1F80 -> only 0x1FC0 issued; busy_o=0 next cycle; drop_count_o unchanged.
3. Negative stride: IP 0x500, addresses 0x2300, 0x22C0, 0x2280, 0x2240 -> 0x2200, 0x21C0, 0x2180, 0x2140.
4. Backpressure: pf_ready_i=0 for 5 cycles mid-burst -> pf_addr_o stable. Exactly 4 unique handshakes in order; no skips or duplicates.
5. Second qualified trigger during a stalled burst -> drop_count_o=1. Trigger on the final-handshake cycle -> new burst's first address presented the next cycle. Assert rst mid-burst -> pf_valid_o=0 next cycle; count stays 0 after reset.
6. NUM_TRACKERS=4, IPs A, B, C, D, A, E -> E replaces B. A later training sequence on B restarts at conf=0: no prefetch until 4 accesses.
